spi_arb_ctrl: RTL and testbench

Transaction scheduler that shares the single SPI byte engine between two requesters. It arbitrates round-robin and owns the per-requester chip selects. It sequences multi-byte transactions byte by byte over a start/done handshake with the engine, and enforces a minimum chip-select deassert gap between transactions. It sits between the user-facing request logic and the SPI shift engine in the top-level SPI design.

---
 rtl/spi_arb_ctrl_if.sv | 31 +++
 rtl/spi_arb_ctrl.sv | 167 ++++++++++++++++
 tb/tb_spi_arb_ctrl.sv | 346 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_arb_ctrl_if.sv
// Bus bundle between the two requesters, the SPI byte engine and the arbiter.
// The slave modport is the arbiter's view; the master modport is the surrounding logic.
interface spi_arb_ctrl_if;
  logic [1:0] req;
  logic [3:0] len0;
  logic [3:0] len1;
  logic [7:0] tx_data0;
  logic [7:0] tx_data1;
  logic [1:0] tx_valid;
  logic [1:0] tx_ready;
  logic [1:0] gnt;
  logic [7:0] rx_data;
  logic [1:0] rx_valid;
  logic       busy;
  logic [1:0] cs_n;
  logic       eng_start;
  logic [7:0] eng_tx;
  logic       eng_done;
  logic [7:0] eng_rx;
  logic [1:0] timeout_err;

  modport master (
    output req, len0, len1, tx_data0, tx_data1, tx_valid, eng_done, eng_rx,
    input  tx_ready, gnt, rx_data, rx_valid, busy, cs_n, eng_start, eng_tx, timeout_err
  );

  modport slave (
    input  req, len0, len1, tx_data0, tx_data1, tx_valid, eng_done, eng_rx,
    output tx_ready, gnt, rx_data, rx_valid, busy, cs_n, eng_start, eng_tx, timeout_err
  );
endinterface

// File: rtl/spi_arb_ctrl.sv
// Round-robin scheduler sharing one SPI byte engine between two requesters, with CS gap.
// Optional WAIT_TX stall abort enabled by defining SPI_ARB_TIMEOUT_EN.
module spi_arb_ctrl #(
  parameter int CS_GAP  = 4,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  spi_arb_ctrl_if.slave     bus
);

  typedef enum logic [1:0] {IDLE, WAIT_TX, XFER, GAP} state_e;

  localparam int GAP_CYC = (CS_GAP < 1) ? 1 : CS_GAP;
  localparam int GW      = $clog2(GAP_CYC + 1);
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYC);

  state_e          state_q, state_d;
  logic [1:0]      gnt_q, gnt_d;
  logic            last_q, last_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic            eng_start_q, eng_start_d;
  logic [7:0]      eng_tx_q, eng_tx_d;
  logic [7:0]      rx_data_q, rx_data_d;
  logic [1:0]      rx_valid_q, rx_valid_d;
  logic [1:0]      tout_q, tout_d;

  logic [1:0]      tx_ready_w;
  logic            accept;
  logic            win1;
  logic            timeout_hit;
  logic [3:0]      len_sel;
  logic [7:0]      data_sel;

  // tx_ready is withheld during the rx_valid cycle so the next byte is offered one cycle later
  for (genvar gi = 0; gi < 2; gi++) begin : g_req
    assign tx_ready_w[gi] = (state_q == WAIT_TX) && gnt_q[gi] && !rx_valid_q[gi];
    assign bus.cs_n[gi]   = ~gnt_q[gi];
  end

  assign accept   = |(bus.tx_valid & tx_ready_w);
  assign win1     = bus.req[1] & (~bus.req[0] | ~last_q);
  assign len_sel  = win1 ? bus.len1 : bus.len0;
  assign data_sel = gnt_q[1] ? bus.tx_data1 : bus.tx_data0;

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int TO_LIM = (TIMEOUT < 1) ? 1 : TIMEOUT;
  localparam int SW     = ($clog2(TO_LIM + 1) > 8) ? $clog2(TO_LIM + 1) : 8;

  logic [SW-1:0] stall_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
    end else if (state_q != WAIT_TX || accept) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_q + 1'b1;
    end
  end

  assign timeout_hit = (stall_q == SW'(TO_LIM - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (|bus.req) state_d = WAIT_TX;
      WAIT_TX: begin
        if (accept)           state_d = XFER;
        else if (timeout_hit) state_d = GAP;
      end
      XFER:    if (bus.eng_done) state_d = (cnt_q == 4'd1) ? GAP : WAIT_TX;
      GAP:     if (gap_q <= GW'(1)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gnt_d       = gnt_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    gap_d       = gap_q;
    eng_start_d = 1'b0;
    eng_tx_d    = eng_tx_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 2'b00;
    tout_d      = 2'b00;
    case (state_q)
      IDLE: begin
        if (|bus.req) begin
          gnt_d  = win1 ? 2'b10 : 2'b01;
          last_d = win1;
          cnt_d  = (len_sel == 4'd0) ? 4'd1 : len_sel;
        end
      end
      WAIT_TX: begin
        if (accept) begin
          eng_tx_d    = data_sel;
          eng_start_d = 1'b1;
        end else if (timeout_hit) begin
          tout_d = gnt_q;
          gnt_d  = 2'b00;
          gap_d  = GAP_LOAD;
        end
      end
      XFER: begin
        if (bus.eng_done) begin
          rx_data_d  = bus.eng_rx;
          rx_valid_d = gnt_q;
          cnt_d      = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            gnt_d = 2'b00;
            gap_d = GAP_LOAD;
          end
        end
      end
      GAP:     gap_d = gap_q - GW'(1);
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt_q       <= 2'b00;
      last_q      <= 1'b1;
      cnt_q       <= 4'd0;
      gap_q       <= '0;
      eng_start_q <= 1'b0;
      eng_tx_q    <= 8'h00;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 2'b00;
      tout_q      <= 2'b00;
    end else begin
      gnt_q       <= gnt_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      gap_q       <= gap_d;
      eng_start_q <= eng_start_d;
      eng_tx_q    <= eng_tx_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      tout_q      <= tout_d;
    end
  end

  assign bus.tx_ready    = tx_ready_w;
  assign bus.gnt         = gnt_q;
  assign bus.rx_data     = rx_data_q;
  assign bus.rx_valid    = rx_valid_q;
  assign bus.busy        = (state_q != IDLE);
  assign bus.eng_start   = eng_start_q;
  assign bus.eng_tx      = eng_tx_q;
  assign bus.timeout_err = tout_q;

endmodule

// File: tb/tb_spi_arb_ctrl.sv
// Directed bench for spi_arb_ctrl: vector table of single transactions plus cycle-level sequences.
// Build with SPI_ARB_TIMEOUT_EN defined to exercise the stall-abort path (TIMEOUT=16).
module tb_spi_arb_ctrl;

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int TB_TO = 16;
`else
  localparam int TB_TO = 255;
`endif
  localparam int ENG_LAT = 2;
  localparam int WMAX    = 400;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_arb_ctrl_if bus ();

  logic eng_done_auto = 1'b0;
  logic stray_done    = 1'b0;
  assign bus.eng_done = eng_done_auto | stray_done;

  spi_arb_ctrl #(.CS_GAP(4), .TIMEOUT(TB_TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Engine model: answers each eng_start with ~eng_tx after ENG_LAT cycles
  initial begin
    bus.eng_rx = 8'h00;
    forever begin
      @(negedge clk);
      if (bus.eng_start && !rst) begin
        logic [7:0] t;
        t = bus.eng_tx;
        repeat (ENG_LAT) @(posedge clk);
        #1;
        eng_done_auto = 1'b1;
        bus.eng_rx    = ~t;
        @(posedge clk);
        #1;
        eng_done_auto = 1'b0;
      end
    end
  end

  // Monitor: cycle stamps and values of every observable event
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] st_log[$];
  logic [7:0] rx_log[$];
  logic [1:0] rv_log[$];
  logic [1:0] rdy_log[$];
  logic [1:0] g_log[$];
  int st_cyc[$], dn_cyc[$], ac_cyc[$], rx_cyc[$], g_cyc[$];
  logic [1:0] gnt_prev = 2'b00;
  logic [1:0] rxv_prev = 2'b00;
  int cs_bad = 0;
  int tout_seen = 0;
  int tout_cyc = 0;
  logic [1:0] tout_cs = 2'b00;

  always @(negedge clk) begin
    if (bus.cs_n !== ~bus.gnt) cs_bad <= cs_bad + 1;
    if (bus.eng_start) begin st_log.push_back(bus.eng_tx); st_cyc.push_back(cyc); end
    if (bus.eng_done) dn_cyc.push_back(cyc);
    if (|(bus.tx_valid & bus.tx_ready)) ac_cyc.push_back(cyc);
    if (|bus.rx_valid) begin
      rx_log.push_back(bus.rx_data);
      rv_log.push_back(bus.rx_valid);
      rx_cyc.push_back(cyc);
    end
    if (|rxv_prev) rdy_log.push_back(bus.tx_ready);
    rxv_prev <= bus.rx_valid;
    if (bus.gnt !== gnt_prev) begin g_log.push_back(bus.gnt); g_cyc.push_back(cyc); end
    gnt_prev <= bus.gnt;
    if (|bus.timeout_err) begin
      tout_seen <= tout_seen + 1;
      tout_cyc  <= cyc;
      tout_cs   <= bus.cs_n;
    end
  end

  task automatic clear_logs();
    st_log.delete(); rx_log.delete(); rv_log.delete(); rdy_log.delete(); g_log.delete();
    st_cyc.delete(); dn_cyc.delete(); ac_cyc.delete(); rx_cyc.delete(); g_cyc.delete();
  endtask

  task automatic wait_gnt(input logic want_set, output int gc);
    int w = 0;
    @(negedge clk);
    while (((bus.gnt != 2'b00) != want_set) && w < WMAX) begin
      @(negedge clk);
      w++;
    end
    if (w >= WMAX) begin
      checks++; errors++;
      $display("FAIL gnt_wait: got gnt=%b expected set=%0d", bus.gnt, want_set);
    end
    gc = cyc;
  endtask

  task automatic wait_idle();
    int w = 0;
    @(negedge clk);
    while (bus.busy && w < WMAX) begin
      @(negedge clk);
      w++;
    end
    if (w >= WMAX) begin
      checks++; errors++;
      $display("FAIL idle_wait: got busy=%b expected 0", bus.busy);
    end
  endtask

  logic [7:0] fb [16];

  task automatic feed(input int k, input int n);
    for (int i = 0; i < n; i++) begin
      int w = 0;
      @(posedge clk);
      #1;
      if (k == 0) bus.tx_data0 = fb[i]; else bus.tx_data1 = fb[i];
      bus.tx_valid[k] = 1'b1;
      @(negedge clk);
      while (!bus.tx_ready[k] && w < WMAX) begin
        @(negedge clk);
        w++;
      end
      if (w >= WMAX) begin
        checks++; errors++;
        $display("FAIL tx_ready_wait: got tx_ready=%b expected bit %0d", bus.tx_ready, k);
      end
      @(posedge clk);
      #1;
      bus.tx_valid[k] = 1'b0;
    end
  endtask

  typedef struct {
    logic [1:0] req;
    logic [3:0] l0;
    logic [3:0] l1;
    logic [7:0] base;
    logic [1:0] egnt;
    int         n;
  } vec_t;

  vec_t vt [6];

  initial begin
    int gc, c0, k;
    logic [7:0] e;

    vt[0] = '{req: 2'b01, l0: 4'd2,  l1: 4'd7, base: 8'h10, egnt: 2'b01, n: 2};
    vt[1] = '{req: 2'b10, l0: 4'd3,  l1: 4'd0, base: 8'h20, egnt: 2'b10, n: 1};
    vt[2] = '{req: 2'b11, l0: 4'd1,  l1: 4'd1, base: 8'h30, egnt: 2'b01, n: 1};
    vt[3] = '{req: 2'b11, l0: 4'd4,  l1: 4'd2, base: 8'h40, egnt: 2'b10, n: 2};
    vt[4] = '{req: 2'b11, l0: 4'd15, l1: 4'd3, base: 8'hF8, egnt: 2'b01, n: 15};
    vt[5] = '{req: 2'b10, l0: 4'd1,  l1: 4'd5, base: 8'h00, egnt: 2'b10, n: 5};

    bus.req = 2'b00; bus.len0 = 4'd0; bus.len1 = 4'd0;
    bus.tx_data0 = 8'h00; bus.tx_data1 = 8'h00; bus.tx_valid = 2'b00;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cs_n", bus.cs_n, 2'b11);
    chk("rst_gnt", bus.gnt, 2'b00);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_outs", {bus.rx_valid, bus.eng_start, bus.tx_ready, bus.timeout_err}, 7'd0);
    chk("rst_data", {bus.eng_tx, bus.rx_data}, 16'h0000);
    @(posedge clk); #1 rst = 1'b0;

    // Both held with len=1: alternating grants, each 5 cycles after the previous release
    clear_logs();
    bus.len0 = 4'd1; bus.len1 = 4'd1; bus.req = 2'b11;
    for (int t = 0; t < 4; t++) begin
      wait_gnt(1'b1, gc);
      k = bus.gnt[1] ? 1 : 0;
      fb[0] = 8'(8'h60 + t);
      if (t == 3) bus.req = 2'b00;
      feed(k, 1);
      wait_gnt(1'b0, gc);
    end
    wait_idle();
    chk("rr_nlog", g_log.size(), 8);
    chk("rr_seq", {g_log[0], g_log[2], g_log[4], g_log[6]}, 8'b01_10_01_10);
    for (int i = 1; i < 6; i += 2) chk("rr_gap", g_cyc[i+1] - g_cyc[i], 5);
    $display("txn rr-hold grants=%b,%b,%b,%b", g_log[0], g_log[2], g_log[4], g_log[6]);

    // Async reset in the middle of XFER, then a normal transaction
    clear_logs();
    bus.len0 = 4'd3; bus.req = 2'b01;
    wait_gnt(1'b1, gc);
    bus.req = 2'b00;
    fb[0] = 8'h11;
    feed(0, 1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_cs_n", bus.cs_n, 2'b11);
    chk("mid_rst_gnt", bus.gnt, 2'b00);
    chk("mid_rst_busy", bus.busy, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (6) @(posedge clk);
    clear_logs();
    bus.len0 = 4'd1; bus.req = 2'b01;
    wait_gnt(1'b1, gc);
    chk("post_rst_gnt", bus.gnt, 2'b01);
    bus.req = 2'b00;
    fb[0] = 8'h5A;
    feed(0, 1);
    wait_idle();
    chk("post_rst_rx", rx_log.size() > 0 ? rx_log[0] : 8'hxx, 8'hA5);
    $display("txn post-reset req0 rx=%0d bytes", rx_log.size());

    // Three-byte cycle-level sequence on requester 0
    clear_logs();
    fb[0] = 8'hAA; fb[1] = 8'h55; fb[2] = 8'hCC;
    @(posedge clk); #1;
    bus.len0 = 4'd3; bus.req = 2'b01;
    c0 = cyc;
    wait_gnt(1'b1, gc);
    chk("seqA_req2gnt", gc - c0, 1);
    bus.req = 2'b00;
    feed(0, 3);
    wait_idle();
    chk("seqA_nstart", st_log.size(), 3);
    chk("seqA_tx", {st_log[0], st_log[1], st_log[2]}, 24'hAA55CC);
    chk("seqA_nrx", rx_log.size(), 3);
    chk("seqA_rx", {rx_log[0], rx_log[1], rx_log[2]}, 24'h55AA33);
    chk("seqA_rxv", {rv_log[0], rv_log[1], rv_log[2]}, 6'b01_01_01);
    for (int i = 0; i < 3; i++) begin
      chk("seqA_acc2start", st_cyc[i] - ac_cyc[i], 1);
      chk("seqA_done2rxv", rx_cyc[i] - dn_cyc[i], 1);
    end
    chk("seqA_rdy_next", {rdy_log[0], rdy_log[1], rdy_log[2]}, 6'b01_01_00);
    chk("seqA_gnt_log", {g_log[0], g_log[1]}, 4'b01_00);
    chk("seqA_release", g_cyc[1], rx_cyc[2]);
    $display("txn seqA tx=%h,%h,%h rx=%h,%h,%h", st_log[0], st_log[1], st_log[2],
             rx_log[0], rx_log[1], rx_log[2]);

    // Vector table
    for (int v = 0; v < 6; v++) begin
      wait_idle();
      clear_logs();
      for (int i = 0; i < 16; i++) fb[i] = 8'(vt[v].base + i);
      @(posedge clk); #1;
      bus.len0 = vt[v].l0; bus.len1 = vt[v].l1; bus.req = vt[v].req;
      wait_gnt(1'b1, gc);
      chk("vec_gnt", bus.gnt, vt[v].egnt);
      bus.req = 2'b00;
      feed(vt[v].egnt[1] ? 1 : 0, vt[v].n);
      wait_idle();
      chk("vec_nrx", rx_log.size(), vt[v].n);
      chk("vec_nstart", st_log.size(), vt[v].n);
      for (int i = 0; i < vt[v].n; i++) begin
        e = ~fb[i];
        chk("vec_rx", {rv_log[i], rx_log[i]}, {vt[v].egnt, e});
      end
      $display("txn vec%0d req=%b gnt=%b bytes=%0d", v, vt[v].req, vt[v].egnt, rx_log.size());
    end

    // Ignored inputs: req drop, other requester's tx_valid, stray eng_done in WAIT_TX
    wait_idle();
    clear_logs();
    fb[0] = 8'h0F; fb[1] = 8'hF0;
    bus.len0 = 4'd2; bus.req = 2'b01;
    wait_gnt(1'b1, gc);
    @(posedge clk); #1;
    bus.req = 2'b00;
    bus.tx_data1 = 8'h77; bus.tx_valid[1] = 1'b1;
    stray_done = 1'b1;
    @(posedge clk); #1;
    stray_done = 1'b0;
    repeat (3) @(negedge clk);
    chk("ign_nstart", st_log.size(), 0);
    chk("ign_nrx", rx_log.size(), 0);
    chk("ign_gnt", bus.gnt, 2'b01);
    feed(0, 2);
    bus.tx_valid[1] = 1'b0;
    wait_idle();
    chk("ign_tx", {st_log[0], st_log[1]}, 16'h0FF0);
    chk("ign_rx_n", rx_log.size(), 2);
    chk("ign_rxv", {rv_log[0], rv_log[1]}, 4'b01_01);
    $display("txn ignored-inputs bytes=%0d", rx_log.size());

    // Requester 0 granted but never offers a byte
    wait_idle();
    clear_logs();
    bus.len0 = 4'd1; bus.req = 2'b01;
    wait_gnt(1'b1, gc);
    bus.req = 2'b00;
`ifdef SPI_ARB_TIMEOUT_EN
    begin
      int w = 0;
      while (tout_seen == 0 && w < WMAX) begin
        @(negedge clk);
        w++;
      end
      @(negedge clk);
      chk("to_seen", tout_seen, 1);
      chk("to_delay", tout_cyc - gc, 16);
      chk("to_cs_n", tout_cs, 2'b11);
      wait_idle();
      chk("to_idle_busy", bus.busy, 1'b0);
      chk("to_nstart", st_log.size(), 0);
      $display("txn timeout delay=%0d", tout_cyc - gc);
    end
`else
    repeat (1000) @(negedge clk);
    chk("stall_gnt", bus.gnt, 2'b01);
    chk("stall_busy", bus.busy, 1'b1);
    chk("stall_noerr", tout_seen, 0);
    fb[0] = 8'hC3;
    feed(0, 1);
    wait_idle();
    chk("stall_rx", rx_log.size() > 0 ? rx_log[0] : 8'hxx, 8'h3C);
    $display("txn stall-1000 then byte rx=%0d", rx_log.size());
`endif

    chk("cs_n_tracks_gnt", cs_bad, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
